// File: rtl/seq_addsub32.sv
// seq_addsub32: multi-cycle add/sub using one reusable SLICE-bit carry-lookahead slice per clock.
module seq_addsub32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int N = WIDTH / SLICE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, next_result;
  logic carry;
  logic [CW-1:0] cnt;
  logic [SLICE-1:0] sa, sb, g, p, c, sum;
  logic gg, gp, slice_cout;
  always_comb begin
    sa = a_r[cnt*SLICE +: SLICE];
    sb = b_r[cnt*SLICE +: SLICE];
    g = sa & sb;
    p = sa ^ sb;
    gg = 1'b0;
    gp = 1'b1;
    c = '0;
    c[0] = carry;
    for (int i = 0; i < SLICE; i++) begin
      gg = g[i] | (p[i] & gg);
      gp = gp & p[i];
      if (i < SLICE - 1) c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum = p ^ c;
    slice_cout = gg | (gp & carry);
    next_result = result;
    next_result[cnt*SLICE +: SLICE] = sum;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      cnt <= '0;
      result <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (state != RUN && start) begin
      a_r <= a;
      b_r <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt <= '0;
      result <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      state <= RUN;
    end else if (state == RUN) begin
      result <= next_result;
      carry <= slice_cout;
      cnt <= cnt + 1'b1;
      // Overflow uses the carry into the MSB, which is the top internal carry of the last slice.
      if (cnt == CW'(N - 1)) begin
        cout <= slice_cout;
        overflow <= c[SLICE-1] ^ slice_cout;
        zero <= next_result == '0;
        busy <= 1'b0;
        done <= 1'b1;
        state <= DONE;
      end
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_addsub32.sv
// tb_seq_addsub32: directed self-checking bench for seq_addsub32.
module tb_seq_addsub32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic busy, done, cout, overflow, zero;
  int compares = 0, fails = 0;
  int n;
  bit seen;
  seq_addsub32 dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    @(negedge clk);
    a = av;
    b = bv;
    sub = sv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask
  task automatic run_check(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic sv, input logic [31:0] er, input logic ec,
                           input logic ev, input logic ez);
    start_op(av, bv, sv);
    check({tag, "_busy"}, busy, 1);
    wait_done(n);
    check({tag, "_lat"}, n, 8);
    check({tag, "_res"}, result, er);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, overflow, ev);
    check({tag, "_zero"}, zero, ez);
    @(negedge clk);
    check({tag, "_pulse"}, {done, busy}, 0);
    check({tag, "_hold"}, result, er);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out", {busy, done, cout, overflow, zero}, 0);
    check("rst_res", result, 0);
    run_check("add_ripple", 32'h0000000F, 32'h00000001, 0, 32'h00000010, 0, 0, 0);
    run_check("wrap_zero", 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0, 1);
    run_check("sub_ovf", 32'h80000000, 32'h00000001, 1, 32'h7FFFFFFF, 1, 1, 0);
    run_check("sub_neg", 32'h00000005, 32'h00000007, 1, 32'hFFFFFFFE, 0, 0, 0);
    // start pulse during RUN must be ignored
    start_op(32'h00000100, 32'h00000023, 0);
    repeat (2) @(negedge clk);
    a = 32'h0000FFFF;
    b = 32'h00000005;
    sub = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ign_lat", n, 5);
    check("ign_res", result, 32'h00000123);
    // back-to-back start in the done cycle
    a = 32'h1;
    b = 32'h2;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_clear", {busy, done, result}, {2'b10, 32'h0});
    wait_done(n);
    check("b2b_lat", n, 8);
    check("b2b_res", result, 32'h3);
    // reset mid-operation
    start_op(32'hDEADBEEF, 32'h1, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("midrst", {busy, done, result}, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= done;
    end
    check("midrst_nodone", seen, 0);
    run_check("post_rst", 32'h12345678, 32'h11111111, 0, 32'h23456789, 0, 0, 0);
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          logic [32:0] m;
          m = {1'b0, 32'(x)} + {1'b0, (s != 0) ? ~32'(y) : 32'(y)} + 33'(s);
          start_op(32'(x), 32'(y), s[0]);
          wait_done(n);
          check($sformatf("nib_%0d_%0d_%0d", s, x, y), {n, result, cout}, {32'd8, m[31:0], m[32]});
        end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule

// File: doc/seq_addsub32.md
Name: seq_addsub32

Overview:
- Multi-cycle 32-bit adder/subtractor built from one reusable 4-bit carry-lookahead slice.
- Processes one nibble per clock, LSB first. Each slice produces group generate (GG) and group propagate (GP); the slice carry-out is GG | (GP & carry-in), and it is registered into the next nibble.
- Sits beside the ALU in the processor framework as the area-cheap arithmetic path. It consumes operands through a start/done handshake.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per clock; the slice is the 4-bit CLA unit.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  sum/difference; held until the next accepted start.
- cout  output  1  carry out of the MSB. For sub, 1 means no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst=1 at a clk edge, from any state, including mid-operation):
  - state goes to IDLE.
  - busy=0, done=0, result=0, cout=0, overflow=0, zero=0.
  - Internal operand registers, carry register and slice counter are cleared. A partially computed result is discarded.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Latch a into A_r and (b XOR {WIDTH{sub}}) into B_r.
  - Set carry register = sub.
  - Set slice counter = 0 and clear result.
  - Go to RUN with busy=1.
- RUN, on each cycle, for k = counter:
  - Slice inputs: A_r[k*SLICE +: SLICE], B_r[same], carry.
  - Per-bit g=a&b, p=a^b. GG = g3 | p3g2 | p3p2g1 | p3p2p1g0. GP = p3&p2&p1&p0.
  - Sum bits: p ^ internal lookahead carries. Write them into result[k*SLICE +: SLICE].
  - carry <= GG | (GP & carry). Counter increments.
- Last slice (counter == WIDTH/SLICE-1):
  - Write cout = final carry.
  - overflow = carry into MSB XOR carry out of MSB, computed inside the last slice.
  - zero = (completed result == 0).
  - Go to DONE with busy=0 and done=1 for exactly that transition cycle's output.
- Latency: start accepted at edge N; done=1 and result valid after edge N+WIDTH/SLICE (8 cycles for defaults).
- DONE: done is high for one cycle only. Outputs are held; the state behaves as IDLE for start.
  - start in the same cycle done is high is accepted, giving back-to-back operation with no bubble. result is then cleared at the next edge.
- start during RUN is ignored. Operands on a/b/sub may change freely during RUN without effect.
- Arithmetic is modulo 2^WIDTH. cout/overflow follow standard two's-complement rules for both add and sub.
- rst and start asserted together: rst wins.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> busy=0, done=0, result=0, cout=0, overflow=0, zero=0.
- Add with carry ripple: a=0x0000000F, b=0x00000001, sub=0, start one cycle -> busy for 8 cycles; done pulse after 8 edges; result=0x00000010, cout=0, overflow=0, zero=0.
- Wrap-around and zero: a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0, cout=1, zero=1, overflow=0.
- Signed overflow, sub:
  - a=0x80000000, b=0x00000001, sub=1 -> result=0x7FFFFFFF, overflow=1, cout=1.
  - a=5, b=7, sub=1 -> result=0xFFFFFFFE, cout=0, overflow=0.
- Handshake:
  - Pulse start again at cycle 3 of RUN with different operands -> ignored; the original result is produced.
  - Assert start in the done cycle with a=1, b=2 -> second done after 8 more edges with result=3.
- Reset mid-operation: assert rst at cycle 4 of RUN -> next cycle busy=0, result=0, no done pulse. A subsequent operation with a=0x12345678, b=0x11111111 gives result=0x23456789.
- Exhaustive low nibble: sweep a[3:0], b[3:0] over 0..15 (upper bits 0) for sub=0 and sub=1 -> result matches a+b or a-b mod 2^32 in every case.
